// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity sense constants and
// the default payload width. Reused by the TX framer and the RX chain.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  // Parity sense selected by par_typ
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Frame states, in transmission order
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial line of the UART TX framer.
// The master is the data source; the slave is uart_tx_frame.
// Optional build macro: UART_TX_TWO_STOP_EN adds the stop_two request bit.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) ();

  logic [DATA_WIDTH-1:0]     data_in;
  logic                      data_valid;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      par_en;
  logic                      par_typ;
`ifdef UART_TX_TWO_STOP_EN
  logic                      stop_two;
`endif
  logic                      tx_out;
  logic                      busy;

`ifdef UART_TX_TWO_STOP_EN
  modport master (
    output data_in, data_valid, Prescale, par_en, par_typ, stop_two,
    input  tx_out, busy
  );

  modport slave (
    input  data_in, data_valid, Prescale, par_en, par_typ, stop_two,
    output tx_out, busy
  );
`else
  modport master (
    output data_in, data_valid, Prescale, par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  data_in, data_valid, Prescale, par_en, par_typ,
    output tx_out, busy
  );
`endif

endinterface : uart_tx_frame_if

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: XOR-reduces the byte, inverting the
// result for odd parity.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Running XOR; the top element is the parity of the whole byte
  logic [DATA_WIDTH-1:0] xor_chain;

  assign xor_chain[0] = data[0];

  generate
    for (genvar gi = 1; gi < DATA_WIDTH; gi++) begin : g_xor
      assign xor_chain[gi] = xor_chain[gi-1] ^ data[gi];
    end
  endgenerate

  // Even parity drives the XOR itself, odd parity its complement
  assign par_bit = (par_typ == PAR_ODD) ? ~xor_chain[DATA_WIDTH-1]
                                        :  xor_chain[DATA_WIDTH-1];

endmodule : uart_tx_parity_calc

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first,
// optional parity, stop. Each bit lasts Prescale clocks. All frame
// settings are captured on the accepting edge so the source may change
// them freely while busy is high.
// Optional build macro: UART_TX_TWO_STOP_EN (stop_two selects a double
// length stop period).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  tx_if
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  uart_state_e               state_q,   state_d;
  logic [PRESCALE_WIDTH-1:0] cyc_q,     cyc_d;
  logic [BIT_W-1:0]          bit_q,     bit_d;
  logic [DATA_WIDTH-1:0]     data_q,    data_d;
  logic [PRESCALE_WIDTH-1:0] presc_q,   presc_d;
  logic                      par_en_q,  par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      tx_q,      tx_d;
  logic                      busy_q,    busy_d;
`ifdef UART_TX_TWO_STOP_EN
  logic                      stop_two_q,   stop_two_d;
  logic                      second_stop_q, second_stop_d;
`endif

  logic [PRESCALE_WIDTH-1:0] presc_m1;
  logic                      last_cyc;
  logic [BIT_W-1:0]          bit_inc;
  logic                      par_bit;

  // Bit period ends when the cycle counter reaches latched Prescale-1;
  // Prescale is never 0 while a frame runs, so this cannot underflow.
  assign presc_m1 = presc_q - 1'b1;
  assign last_cyc = (cyc_q == presc_m1);
  assign bit_inc  = bit_q + 1'b1;

  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (data_q),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );

  // Next-state, counter and next-output computation for the frame FSM
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    data_d    = data_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
`ifdef UART_TX_TWO_STOP_EN
    stop_two_d    = stop_two_q;
    second_stop_d = second_stop_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_if.data_valid && (tx_if.Prescale != '0)) begin
          data_d    = tx_if.data_in;
          presc_d   = tx_if.Prescale;
          par_en_d  = tx_if.par_en;
          par_typ_d = tx_if.par_typ;
`ifdef UART_TX_TWO_STOP_EN
          stop_two_d    = tx_if.stop_two;
          second_stop_d = 1'b0;
`endif
          cyc_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end

      START: begin
        if (last_cyc) begin
          cyc_d   = '0;
          tx_d    = data_q[0];
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      DATA: begin
        if (last_cyc) begin
          cyc_d = '0;
          if (bit_q == LAST_BIT) begin
            if (par_en_q) begin
              tx_d    = par_bit;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d = bit_inc;
            tx_d  = data_q[bit_inc];
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      PARITY: begin
        if (last_cyc) begin
          cyc_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      STOP: begin
        if (last_cyc) begin
          cyc_d = '0;
`ifdef UART_TX_TWO_STOP_EN
          if (stop_two_q && !second_stop_q) begin
            // Re-arm the counter for the second stop period; line stays high
            second_stop_d = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cyc_d   = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, counters, latched frame settings and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_two_q    <= 1'b0;
      second_stop_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_two_q    <= stop_two_d;
      second_stop_q <= second_stop_d;
`endif
    end
  end

  assign tx_if.tx_out = tx_q;
  assign tx_if.busy   = busy_q;

endmodule : uart_tx_frame
